// File: rtl/relprime_pkg.sv
// Shared types and constants for the relPrime datapath select stages.
package relprime_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam logic [15:0] MUX_DEFAULT = 16'd15;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry FIFO-ordered skid buffer with valid/ready on both sides.
// Latency 1 cycle from accept to out_vld; in_rdy drops only when both entries are held.
module skid_buf2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_dat,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_dat,
  output logic         out_vld,
  input  logic         out_rdy
);
  import relprime_pkg::*;

  occ_e         occ_q, occ_d;
  logic [W-1:0] main_q, skid_q;
  logic         load_main, main_from_skid, load_skid;
  logic         acc, dlv;

  // Handshake outputs depend on registered occupancy only, never on out_rdy.
  assign in_rdy  = (occ_q != OCC_FULL);
  assign out_vld = (occ_q != OCC_EMPTY);
  assign out_dat = main_q;

  assign acc = in_vld && in_rdy;
  assign dlv = out_vld && out_rdy;

  always_comb begin
    occ_d          = occ_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        if (acc) begin
          load_main = 1'b1;
          occ_d     = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (acc && dlv) begin
          load_main = 1'b1;
        end else if (acc) begin
          load_skid = 1'b1;
          occ_d     = OCC_FULL;
        end else if (dlv) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (dlv) begin
          main_from_skid = 1'b1;
          occ_d          = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (main_from_skid)
        main_q <= skid_q;
      else if (load_main)
        main_q <= in_dat;
      if (load_skid)
        skid_q <= in_dat;
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-way operand select with default for out-of-range selectors and a sticky error count.
// Latency 1 cycle; stalls via a 2-entry skid buffer, in_ready low only when both entries are full.
module mux_n_reg #(
  parameter int             N       = 6,
  parameter int             W       = 16,
  parameter int             SEL_W   = 3,
  parameter logic [W-1:0]   DEFAULT = W'(relprime_pkg::MUX_DEFAULT),
  parameter int             CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [N*W-1:0]     in_data,
  input  logic [SEL_W-1:0]   Selector,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [W-1:0]       result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               bad_sel,
  output logic [CNT_W-1:0]   bad_count,
  input  logic               clear_err
);
  import relprime_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0] sel_dat;
  logic         sel_hit;
  logic         accept;

  always_comb begin
    sel_dat = DEFAULT;
    sel_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (Selector == SEL_W'(k)) begin
        sel_dat = in_data[k*W +: W];
        sel_hit = 1'b1;
      end
    end
  end

  assign accept = in_valid && in_ready;

  skid_buf2 #(.W(W)) u_skid (
    .clk     (CLK),
    .rst     (Reset),
    .in_dat  (sel_dat),
    .in_vld  (in_valid),
    .in_rdy  (in_ready),
    .out_dat (result),
    .out_vld (out_valid),
    .out_rdy (out_ready)
  );

  // A clear wins over a same-cycle bad accept so software never loses a fresh zero.
  always_ff @(posedge CLK) begin
    if (Reset || clear_err) begin
      bad_sel   <= 1'b0;
      bad_count <= '0;
    end else if (accept && !sel_hit) begin
      bad_sel <= 1'b1;
      if (bad_count != CNT_MAX)
        bad_count <= bad_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/mux_n_reg.md
# mux_n_reg

Parametrised, pipelined N-way operand select stage for the relPrime datapath, replacing fixed-width combinational selectors. One of N W-bit sources is selected per transaction, registered, and delivered through a valid/ready handshake with a 2-entry skid buffer, so the stage can stall without dropping data. Out-of-range selectors produce a programmable default value and are flagged and counted for debug.

## Interface
- `N`, 6, number of source operands (2..16)
- `W`, 16, operand width in bits
- `SEL_W`, 3, selector width; must satisfy 2^SEL_W >= N
- `DEFAULT`, 15, W-bit value output when selector >= N
- `CNT_W`, 8, width of the bad-select counter

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `Reset`  in  1  synchronous, active-high reset
- `in_data`  in  N*W  packed sources; source k occupies bits [k*W+W-1 : k*W]
- `Selector`  in  SEL_W  source index, sampled with `in_data` on acceptance
- `in_valid`  in  1  upstream transaction present
- `in_ready`  out  1  stage can accept a transaction
- `result`  out  W  selected operand
- `out_valid`  out  1  `result` is valid
- `out_ready`  in  1  downstream accepts `result`
- `bad_sel`  out  1  sticky: at least one out-of-range selector was accepted
- `bad_count`  out  CNT_W  saturating count of accepted out-of-range selectors
- `clear_err`  in  1  clears `bad_sel` and `bad_count`

## Operation
- Accept: `in_valid && in_ready`. Deliver: `out_valid && out_ready`.
- On accept, the value `Selector < N ? source[Selector] : DEFAULT` enters the skid buffer. A W-bit and `Selector` are captured in the same cycle; later changes to inputs do not affect stored entries.
- Skid buffer: 2 entries (main, skid), FIFO order. Occupancy states:
  - EMPTY: `out_valid`=0, `in_ready`=1
  - ONE: `out_valid`=1, `in_ready`=1
  - FULL: `out_valid`=1, `in_ready`=0
- Transitions:
  - EMPTY->ONE on accept.
  - ONE->FULL on accept without deliver.
  - ONE->EMPTY on deliver without accept.
  - ONE stays ONE on simultaneous accept and deliver; the new value replaces main.
  - FULL->ONE on deliver; skid moves to main.
- `result` always shows the main entry. It holds its value while `out_valid && !out_ready`, and holds its last value when EMPTY.
- Error logic:
  - An accepted out-of-range selector sets `bad_sel` and increments `bad_count`.
  - `bad_count` saturates at 2^CNT_W-1.
  - `clear_err` has priority over a same-cycle increment: the result is 0, and `bad_sel`=0.
  - Non-accepted (stalled or invalid) out-of-range selectors are ignored.

## Timing
- Reset values: occupancy EMPTY, `out_valid`=0, `in_ready`=1, `result`=0, `bad_sel`=0, `bad_count`=0.
- `Reset` mid-transaction discards both buffered entries; no delivery follows.
- Latency: an accept in cycle t gives `out_valid`=1 with that value in cycle t+1 (from EMPTY).
- Throughput: 1 transaction per cycle while `out_ready`=1.
- `in_ready` is a registered function of occupancy only. There is no combinational path from `out_ready` to `in_ready`.
- All outputs are registered or decoded from registered state. The only combinational path is input mux -> buffer D-inputs.

## Structure
- Shared package `relprime_pkg`:
  - occupancy state encoding (`OCC_EMPTY`, `OCC_ONE`, `OCC_FULL`)
  - legacy default constant `MUX_DEFAULT = 16'd15`
- Sub-module `skid_buf2`, parametrised on W:
  - contains the 2-entry buffer, handshake and occupancy FSM
  - `mux_n_reg` holds the select/default decode and error counter around it

## Test plan
- N=6, W=16: sources 100..105, `Selector`=3, `in_valid`=1 for one cycle, `out_ready`=1 -> `result`=103 with `out_valid`=1 exactly one cycle later, then `out_valid`=0.
- `Selector`=6 then 7 on consecutive accepts -> `result`=15 twice, `bad_sel`=1, `bad_count`=2. Pulse `clear_err` -> both 0 next cycle.
- Hold `out_ready`=0, offer selectors 0, 1, 2 back-to-back -> `in_ready` drops after two accepts (FULL). Release `out_ready` -> `result` shows 100, 101, then 102, in order, with no loss or duplication.
- Streaming: `in_valid`=`out_ready`=1 for 20 cycles with `Selector` cycling 0..5 -> one output per cycle, `in_ready` never low.
- Assert `Reset` while FULL -> next cycle `out_valid`=0, `in_ready`=1, `result`=0, counters 0. Held value is not delivered.
- Saturation with CNT_W=2: accept 5 out-of-range selectors -> `bad_count` stays 3. `clear_err` coincident with a bad accept -> `bad_count`=0.
